// File: rtl/instruction_decode_pkg.sv
// Shared decode definitions: opcode/funct encodings, ALU codes, NOP word,
// the ID/EX control bundle and an immediate sign-extension helper.
package decode_pkg;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    // ALU operation codes seen by execute
    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_AND  = 3'd2;
    localparam logic [2:0] ALU_OR   = 3'd3;
    localparam logic [2:0] ALU_SLT  = 3'd4;

    // sll $0,$0,0 -- the canonical bubble word
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Control part of the ID/EX bundle; all-zero is a bubble
    typedef struct packed {
        logic       valid;
        logic [4:0] dest;
        logic [2:0] alu_ctrl;
        logic       alu_src_imm;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
    } ctrl_t;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/instruction_decode_regfile.sv
// 32x32 register file: $0 hardwired to zero, one write port, two
// combinational read ports that forward a same-cycle write-back.
module regfile (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  i_rs_addr,
    input  logic [4:0]  i_rt_addr,
    output logic [31:0] o_rs_val,
    output logic [31:0] o_rt_val,
    input  logic        i_wb_en,
    input  logic [4:0]  i_wb_reg,
    input  logic [31:0] i_wb_data
);

    logic [31:0] r_regs [32];

    // Storage: cleared on reset, written at the edge when write-back is enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= 32'd0;
            end
        end else if (i_wb_en && (i_wb_reg != 5'd0)) begin
            r_regs[i_wb_reg] <= i_wb_data;
        end
    end

    // rs read port with $0 forcing and write-back forwarding
    always_comb begin
        o_rs_val = r_regs[i_rs_addr];
        if (i_rs_addr == 5'd0) begin
            o_rs_val = 32'd0;
        end else if (i_wb_en && (i_wb_reg == i_rs_addr)) begin
            o_rs_val = i_wb_data;
        end else begin
            o_rs_val = r_regs[i_rs_addr];
        end
    end

    // rt read port with $0 forcing and write-back forwarding
    always_comb begin
        o_rt_val = r_regs[i_rt_addr];
        if (i_rt_addr == 5'd0) begin
            o_rt_val = 32'd0;
        end else if (i_wb_en && (i_wb_reg == i_rt_addr)) begin
            o_rt_val = i_wb_data;
        end else begin
            o_rt_val = r_regs[i_rt_addr];
        end
    end

endmodule

// File: rtl/instruction_decode.sv
// Decode stage: IF/ID register, decoder, register file read, branch/jump
// resolution, load-use hazard detection and the registered ID/EX bundle.
module instruction_decode
    import decode_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr_in,
    input  logic        wb_en,
    input  logic [4:0]  wb_reg,
    input  logic [31:0] wb_data,
    output logic        is_jump,
    output logic        is_branch,
    output logic [15:0] imm16,
    output logic [25:0] addr26,
    output logic        stall,
    output logic        ex_valid,
    output logic [31:0] ex_rs_val,
    output logic [31:0] ex_rt_val,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_dest,
    output logic [2:0]  ex_alu_ctrl,
    output logic        ex_alu_src_imm,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic        ex_reg_write,
    output logic        illegal
);

    logic [31:0] r_ifid;
    ctrl_t       r_ex_ctrl;
    logic [31:0] r_ex_rs_val;
    logic [31:0] r_ex_rt_val;
    logic [31:0] r_ex_imm;

    logic [5:0]  w_op;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [5:0]  w_funct;
    logic [15:0] w_imm16;
    logic [31:0] w_rs_val;
    logic [31:0] w_rt_val;
    ctrl_t       w_ctrl;
    logic        w_legal;
    logic        w_nop;
    logic        w_uses_rs;
    logic        w_rt_src;
    logic        w_is_beq;
    logic        w_is_bne;
    logic        w_is_j;
    logic        w_taken;
    logic        w_stall;

    assign w_op    = r_ifid[31:26];
    assign w_rs    = r_ifid[25:21];
    assign w_rt    = r_ifid[20:16];
    assign w_rd    = r_ifid[15:11];
    assign w_funct = r_ifid[5:0];
    assign w_imm16 = r_ifid[15:0];
    assign w_nop   = (r_ifid == NOP_INSTR);

    regfile u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_rs_addr (w_rs),
        .i_rt_addr (w_rt),
        .o_rs_val  (w_rs_val),
        .o_rt_val  (w_rt_val),
        .i_wb_en   (wb_en),
        .i_wb_reg  (wb_reg),
        .i_wb_data (wb_data)
    );

    // Decoder: control bundle plus operand-usage flags for the IF/ID word
    always_comb begin
        w_ctrl    = '0;
        w_legal   = 1'b0;
        w_uses_rs = 1'b0;
        w_rt_src  = 1'b0;
        w_is_beq  = 1'b0;
        w_is_bne  = 1'b0;
        w_is_j    = 1'b0;
        if (w_nop) begin
            w_legal = 1'b0;
        end else begin
            case (w_op)
                OP_RTYPE: begin
                    w_ctrl.dest      = w_rd;
                    w_ctrl.reg_write = 1'b1;
                    w_uses_rs        = 1'b1;
                    w_rt_src         = 1'b1;
                    w_legal          = 1'b1;
                    case (w_funct)
                        FN_ADD:  w_ctrl.alu_ctrl = ALU_ADD;
                        FN_SUB:  w_ctrl.alu_ctrl = ALU_SUB;
                        FN_AND:  w_ctrl.alu_ctrl = ALU_AND;
                        FN_OR:   w_ctrl.alu_ctrl = ALU_OR;
                        FN_SLT:  w_ctrl.alu_ctrl = ALU_SLT;
                        default: w_legal         = 1'b0;
                    endcase
                end
                OP_ADDI: begin
                    w_ctrl.dest        = w_rt;
                    w_ctrl.alu_src_imm = 1'b1;
                    w_ctrl.reg_write   = 1'b1;
                    w_uses_rs          = 1'b1;
                    w_legal            = 1'b1;
                end
                OP_LW: begin
                    w_ctrl.dest        = w_rt;
                    w_ctrl.alu_src_imm = 1'b1;
                    w_ctrl.mem_read    = 1'b1;
                    w_ctrl.reg_write   = 1'b1;
                    w_uses_rs          = 1'b1;
                    w_legal            = 1'b1;
                end
                OP_SW: begin
                    w_ctrl.alu_src_imm = 1'b1;
                    w_ctrl.mem_write   = 1'b1;
                    w_uses_rs          = 1'b1;
                    w_rt_src           = 1'b1;
                    w_legal            = 1'b1;
                end
                OP_BEQ: begin
                    w_ctrl.alu_ctrl = ALU_SUB;
                    w_uses_rs       = 1'b1;
                    w_rt_src        = 1'b1;
                    w_is_beq        = 1'b1;
                    w_legal         = 1'b1;
                end
                OP_BNE: begin
                    w_ctrl.alu_ctrl = ALU_SUB;
                    w_uses_rs       = 1'b1;
                    w_rt_src        = 1'b1;
                    w_is_bne        = 1'b1;
                    w_legal         = 1'b1;
                end
                OP_J: begin
                    // bits 25:21 are target bits here, not a register source
                    w_is_j  = 1'b1;
                    w_legal = 1'b1;
                end
                default: begin
                    w_legal = 1'b0;
                end
            endcase
        end
        w_ctrl.valid = w_legal;
    end

    // Load-use hazard against the lw currently sitting in ID/EX
    assign w_stall = r_ex_ctrl.valid && r_ex_ctrl.mem_read && (r_ex_ctrl.dest != 5'd0) && w_legal &&
                     ((w_uses_rs && (r_ex_ctrl.dest == w_rs)) || (w_rt_src && (r_ex_ctrl.dest == w_rt)));

    // Branch outcome from the forwarded operands
    always_comb begin
        if (w_is_beq) begin
            w_taken = (w_rs_val == w_rt_val);
        end else if (w_is_bne) begin
            w_taken = (w_rs_val != w_rt_val);
        end else begin
            w_taken = 1'b0;
        end
    end

    assign stall     = w_stall;
    assign is_jump   = w_is_j && !w_stall;
    assign is_branch = w_taken && !w_stall;
    assign imm16     = r_ifid[15:0];
    assign addr26    = r_ifid[25:0];
    assign illegal   = !w_legal && !w_nop;

    // IF/ID: hold on stall, flush on redirect (no delay slot), else advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ifid <= NOP_INSTR;
        end else if (w_stall) begin
            r_ifid <= r_ifid;
        end else if (is_jump || is_branch) begin
            r_ifid <= NOP_INSTR;
        end else begin
            r_ifid <= instr_in;
        end
    end

    // ID/EX: bubble on stall, NOP or illegal word, else capture decode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_ctrl   <= '0;
            r_ex_rs_val <= 32'd0;
            r_ex_rt_val <= 32'd0;
            r_ex_imm    <= 32'd0;
        end else if (w_stall || !w_legal) begin
            r_ex_ctrl   <= '0;
            r_ex_rs_val <= 32'd0;
            r_ex_rt_val <= 32'd0;
            r_ex_imm    <= 32'd0;
        end else begin
            r_ex_ctrl   <= w_ctrl;
            r_ex_rs_val <= w_rs_val;
            r_ex_rt_val <= w_rt_val;
            r_ex_imm    <= sext16(w_imm16);
        end
    end

    assign ex_valid       = r_ex_ctrl.valid;
    assign ex_dest        = r_ex_ctrl.dest;
    assign ex_alu_ctrl    = r_ex_ctrl.alu_ctrl;
    assign ex_alu_src_imm = r_ex_ctrl.alu_src_imm;
    assign ex_mem_read    = r_ex_ctrl.mem_read;
    assign ex_mem_write   = r_ex_ctrl.mem_write;
    assign ex_reg_write   = r_ex_ctrl.reg_write;
    assign ex_rs_val      = r_ex_rs_val;
    assign ex_rt_val      = r_ex_rt_val;
    assign ex_imm         = r_ex_imm;

endmodule

// File: tb/tb_instruction_decode.sv
// Bench for instruction_decode: directed scenarios plus random instruction
// streams, each cycle checked against an instruction-level reference model.
module tb_instruction_decode;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr_in;
    logic        wb_en;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        is_jump, is_branch, stall, ex_valid, illegal;
    logic [15:0] imm16;
    logic [25:0] addr26;
    logic [31:0] ex_rs_val, ex_rt_val, ex_imm;
    logic [4:0]  ex_dest;
    logic [2:0]  ex_alu_ctrl;
    logic        ex_alu_src_imm, ex_mem_read, ex_mem_write, ex_reg_write;

    int total = 0;
    int bad   = 0;

    instruction_decode dut (
        .clk(clk), .rst_n(rst_n), .instr_in(instr_in),
        .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
        .is_jump(is_jump), .is_branch(is_branch), .imm16(imm16), .addr26(addr26),
        .stall(stall), .ex_valid(ex_valid), .ex_rs_val(ex_rs_val), .ex_rt_val(ex_rt_val),
        .ex_imm(ex_imm), .ex_dest(ex_dest), .ex_alu_ctrl(ex_alu_ctrl),
        .ex_alu_src_imm(ex_alu_src_imm), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        bit          valid;
        logic [31:0] rs_val, rt_val, imm;
        logic [4:0]  dest;
        logic [2:0]  alu;
        bit          srcimm, mr, mw, rw;
    } ex_t;

    logic [31:0] m_regs [32];
    logic [31:0] m_ifid;
    ex_t         m_ex;

    function automatic ex_t bubble();
        ex_t e;
        e.valid = 0; e.rs_val = 32'd0; e.rt_val = 32'd0; e.imm = 32'd0;
        e.dest = 5'd0; e.alu = 3'd0; e.srcimm = 0; e.mr = 0; e.mw = 0; e.rw = 0;
        return e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_ifid = 32'd0;
        m_ex   = bubble();
    endtask

    // kind: 0 plain, 1 beq, 2 bne, 3 j
    function automatic void mdec(input logic [31:0] w, output bit legal, output bit rs_used,
                                 output bit rt_used, output int kind, output ex_t e);
        int op, fn, rt, rd, im;
        op = int'(w >> 26); fn = int'(w % 64);
        rt = int'((w >> 16) % 32); rd = int'((w >> 11) % 32);
        im = int'(w % 65536);
        e = bubble(); legal = 0; rs_used = 0; rt_used = 0; kind = 0;
        if (w == 32'd0) return;
        e.imm = (im >= 32768) ? 32'(im) + 32'hFFFF_0000 : 32'(im);
        if (op == 0) begin
            legal = 1; rs_used = 1; rt_used = 1; e.dest = 5'(rd); e.rw = 1;
            if (fn == 32) e.alu = 3'd0;
            else if (fn == 34) e.alu = 3'd1;
            else if (fn == 36) e.alu = 3'd2;
            else if (fn == 37) e.alu = 3'd3;
            else if (fn == 42) e.alu = 3'd4;
            else legal = 0;
        end else if (op == 8 || op == 35) begin
            legal = 1; rs_used = 1; e.dest = 5'(rt); e.rw = 1; e.srcimm = 1; e.mr = (op == 35);
        end else if (op == 43) begin
            legal = 1; rs_used = 1; rt_used = 1; e.srcimm = 1; e.mw = 1;
        end else if (op == 4 || op == 5) begin
            legal = 1; rs_used = 1; rt_used = 1; e.alu = 3'd1; kind = (op == 4) ? 1 : 2;
        end else if (op == 2) begin
            legal = 1; kind = 3;
        end
        e.valid = legal;
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check outputs mid-cycle against the model,
    // advance the model, return just after the rising edge.
    task automatic step(input logic [31:0] ins, input bit we, input logic [4:0] wr, input logic [31:0] wd);
        bit legal, rs_used, rt_used, haz, br, jmp, ill;
        int kind;
        ex_t e;
        logic [4:0] rs, rt;
        logic [31:0] rsv, rtv;
        instr_in = ins; wb_en = we; wb_reg = wr; wb_data = wd;
        @(negedge clk);
        mdec(m_ifid, legal, rs_used, rt_used, kind, e);
        rs = m_ifid[25:21]; rt = m_ifid[20:16];
        rsv = (rs == 5'd0) ? 32'd0 : ((we && wr == rs) ? wd : m_regs[rs]);
        rtv = (rt == 5'd0) ? 32'd0 : ((we && wr == rt) ? wd : m_regs[rt]);
        haz = m_ex.valid && m_ex.mr && m_ex.dest != 5'd0 && legal &&
              ((rs_used && m_ex.dest == rs) || (rt_used && m_ex.dest == rt));
        br  = !haz && ((kind == 1 && rsv == rtv) || (kind == 2 && rsv != rtv));
        jmp = !haz && kind == 3;
        ill = !legal && m_ifid != 32'd0;
        chk("stall", 32'(stall), 32'(haz));
        chk("is_branch", 32'(is_branch), 32'(br));
        chk("is_jump", 32'(is_jump), 32'(jmp));
        chk("illegal", 32'(illegal), 32'(ill));
        chk("imm16", 32'(imm16), m_ifid % 65536);
        chk("addr26", 32'(addr26), m_ifid % 67108864);
        chk("ex_valid", 32'(ex_valid), 32'(m_ex.valid));
        chk("ex_rs_val", ex_rs_val, m_ex.rs_val);
        chk("ex_rt_val", ex_rt_val, m_ex.rt_val);
        chk("ex_imm", ex_imm, m_ex.imm);
        chk("ex_dest", 32'(ex_dest), 32'(m_ex.dest));
        chk("ex_alu_ctrl", 32'(ex_alu_ctrl), 32'(m_ex.alu));
        chk("ex_ctl", {28'd0, ex_alu_src_imm, ex_mem_read, ex_mem_write, ex_reg_write},
            {28'd0, m_ex.srcimm, m_ex.mr, m_ex.mw, m_ex.rw});
        if (haz) begin
            m_ex = bubble();
        end else begin
            if (legal) begin
                e.rs_val = rsv; e.rt_val = rtv; m_ex = e;
            end else begin
                m_ex = bubble();
            end
            m_ifid = (br || jmp) ? 32'd0 : ins;
        end
        if (we && wr != 5'd0) m_regs[wr] = wd;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rnd_instr();
        int k;
        logic [4:0] rs, rt, rd;
        logic [15:0] im;
        logic [5:0] fl [5];
        fl[0] = 6'h20; fl[1] = 6'h22; fl[2] = 6'h24; fl[3] = 6'h25; fl[4] = 6'h2A;
        k  = $urandom_range(0, 11);
        rs = 5'($urandom_range(0, 3)); rt = 5'($urandom_range(0, 3)); rd = 5'($urandom_range(0, 3));
        im = 16'($urandom);
        case (k)
            0, 1:    return {6'h00, rs, rt, rd, 5'd0, fl[$urandom_range(0, 4)]};
            2:       return {6'h08, rs, rt, im};
            3, 4:    return {6'h23, rs, rt, im};
            5:       return {6'h2B, rs, rt, im};
            6:       return {6'h04, rs, rt, im};
            7:       return {6'h05, rs, rt, im};
            8:       return {6'h02, 26'($urandom)};
            9:       return 32'd0;
            10:      return {6'h00, rs, rt, rd, 5'd0, 6'h21};
            default: return {6'h3F, 26'($urandom)};
        endcase
    endfunction

    logic [31:0] rdata;

    initial begin
        rst_n = 1'b0; instr_in = 32'd0; wb_en = 1'b0; wb_reg = 5'd0; wb_data = 32'd0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ex_valid", 32'(ex_valid), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_redirect", {30'd0, is_jump, is_branch}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // addi $1,$0,5
        step(32'h2001_0005, 0, 5'd0, 32'd0);
        step(32'd0, 0, 5'd0, 32'd0);
        chk("t2_valid", 32'(ex_valid), 32'd1);
        chk("t2_dest", 32'(ex_dest), 32'd1);
        chk("t2_imm", ex_imm, 32'd5);
        chk("t2_alu", 32'(ex_alu_ctrl), 32'd0);
        chk("t2_srcimm_rw", {30'd0, ex_alu_src_imm, ex_reg_write}, 32'd3);

        // lw $2,0($1) then add $3,$2,$2 -> one stall cycle
        step(32'h8C22_0000, 0, 5'd0, 32'd0);
        step(32'h0042_1820, 0, 5'd0, 32'd0);
        chk("t3_stall", 32'(stall), 32'd1);
        step(32'd0, 0, 5'd0, 32'd0);
        chk("t3_bubble", 32'(ex_valid), 32'd0);
        chk("t3_stall_gone", 32'(stall), 32'd0);
        step(32'd0, 0, 5'd0, 32'd0);
        chk("t3_add_dest", 32'(ex_dest), 32'd3);

        // beq $0,$0,3 taken, following word flushed
        step(32'h1000_0003, 0, 5'd0, 32'd0);
        chk("t4_branch", 32'(is_branch), 32'd1);
        chk("t4_imm16", 32'(imm16), 32'd3);
        step(32'h2001_0005, 0, 5'd0, 32'd0);
        step(32'd0, 0, 5'd0, 32'd0);
        chk("t4_flushed", 32'(ex_valid), 32'd0);
        step(32'h1400_0003, 0, 5'd0, 32'd0);
        chk("t4_bne_not_taken", 32'(is_branch), 32'd0);
        step(32'd0, 0, 5'd0, 32'd0);

        // j 0x10, following word flushed
        step(32'h0800_0010, 0, 5'd0, 32'd0);
        chk("t5_jump", 32'(is_jump), 32'd1);
        chk("t5_addr26", 32'(addr26), 32'h10);
        step(32'h2001_0005, 0, 5'd0, 32'd0);
        step(32'd0, 0, 5'd0, 32'd0);
        chk("t5_flushed", 32'(ex_valid), 32'd0);

        // write-back bypass, $0 write ignored, illegal pulse
        step(32'h00A0_0020, 0, 5'd0, 32'd0);
        step(32'd0, 1, 5'd5, 32'hDEAD_BEEF);
        chk("t6_bypass", ex_rs_val, 32'hDEAD_BEEF);
        step(32'h0000_0020, 0, 5'd0, 32'd0);
        step(32'd0, 1, 5'd0, 32'h1234_5678);
        chk("t6_r0_zero", ex_rs_val, 32'd0);
        step(32'hFC00_0000, 0, 5'd0, 32'd0);
        chk("t6_illegal", 32'(illegal), 32'd1);
        step(32'd0, 0, 5'd0, 32'd0);
        chk("t6_illegal_once", 32'(illegal), 32'd0);

        // random streams with write-back traffic
        for (int n = 0; n < 400; n++) begin
            rdata = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 1)) : 32'($urandom);
            step(rnd_instr(), $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)), rdata);
        end
        step(32'd0, 0, 5'd0, 32'd0);

        // reset mid-stall after writing $5
        step(32'd0, 1, 5'd5, 32'h0000_0055);
        step(32'h8C22_0000, 0, 5'd0, 32'd0);
        step(32'h0042_1820, 0, 5'd0, 32'd0);
        chk("t1_pre_stall", 32'(stall), 32'd1);
        instr_in = 32'd0; wb_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t1_ex_valid", 32'(ex_valid), 32'd0);
        chk("t1_ex_bundle", ex_rs_val | ex_rt_val | ex_imm | 32'(ex_dest) | 32'(ex_alu_ctrl), 32'd0);
        chk("t1_ex_ctl", {28'd0, ex_alu_src_imm, ex_mem_read, ex_mem_write, ex_reg_write}, 32'd0);
        chk("t1_stall", 32'(stall), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(32'h00A0_0020, 0, 5'd0, 32'd0);
        step(32'd0, 0, 5'd0, 32'd0);
        chk("t1_r5_cleared", ex_rs_val, 32'd0);
        chk("t1_valid_after", 32'(ex_valid), 32'd1);
        step(32'd0, 0, 5'd0, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
